lvds_align_ctrl: RTL and testbench
==================================

LVDS_ALIGN_CTRL -- requirements
Module: lvds_align_ctrl

Interface
REQ-001 SHALL have parameters: NUM_LANES, default 4, number of deserialized lanes.
REQ-002 SHALL have parameters: WORDWIDTH, default 6, bits per lane word.
REQ-003 SHALL have parameters: TRAIN_PATTERN, default 6'b111000, expected training word.
REQ-004 SHALL have parameters: SETTLE_CYC, default 4, wait cycles after any slip/tap action.
REQ-005 SHALL have parameters: MATCH_CNT, default 8, consecutive matches needed to lock.
REQ-006 SHALL have parameters: MAX_TAPS, default 32, delay taps available per lane.
REQ-007 SHALL have one clock and an asynchronous, active-low reset; reset polarity and synchronicity are fixed.
REQ-008 SHALL have port i_clk, input, 1 bit: frame-rate clock for parallel words.
REQ-009 SHALL have port i_rst_n, input, 1 bit: async active-low reset.
REQ-010 SHALL have port i_start, input, 1 bit: one-cycle training request.
REQ-011 SHALL have port i_lane_words, input, NUM_LANES*WORDWIDTH bits: parallel words, lane k at bits [k*WORDWIDTH +: WORDWIDTH].
REQ-012 SHALL have port o_bitslip, output, NUM_LANES bits: one-hot bitslip pulse.
REQ-013 SHALL have port o_dly_ce, output, NUM_LANES bits: one-hot delay-step enable.
REQ-014 SHALL have port o_dly_inc, output, 1 bit: delay increment direction, always 1 with CE.
REQ-015 SHALL have port o_dly_ld, output, NUM_LANES bits: load delay taps to 0.
REQ-016 SHALL have port o_busy, output, 1 bit: training in progress.
REQ-017 SHALL have port o_done, output, 1 bit: training finished; held until next accepted start.
REQ-018 SHALL have port o_lane_ok, output, NUM_LANES bits: per-lane lock result.
REQ-019 SHALL have port o_tap, output, 5 bits: current tap of the lane under training.

Function
REQ-020 SHALL implement states IDLE, LOAD, SETTLE, CHECK, SLIP, TAP, NEXT, DONE.
REQ-021 IDLE: on i_start=1 SHALL go to LOAD with lane=0, and SHALL clear o_done and o_lane_ok; o_busy=1 from the next cycle.
REQ-022 LOAD: SHALL pulse o_dly_ld[lane] for 1 cycle, set tap=0 and slip_cnt=0, then go to SETTLE.
REQ-023 SETTLE: SHALL count SETTLE_CYC cycles with no comparison, then go to CHECK with match_cnt=0.
REQ-024 CHECK: SHALL compare the word of the current lane to TRAIN_PATTERN each cycle; on a match, match_cnt SHALL increment, and on reaching MATCH_CNT, o_lane_ok[lane] SHALL be set and the FSM SHALL go to NEXT.
REQ-025 CHECK mismatch: if slip_cnt < WORDWIDTH-1, the FSM SHALL go to SLIP; otherwise it SHALL go to TAP.
REQ-026 SLIP: SHALL pulse o_bitslip[lane] for exactly 1 cycle, increment slip_cnt, then go to SETTLE.
REQ-027 TAP: if tap < MAX_TAPS-1, SHALL pulse o_dly_ce[lane] with o_dly_inc=1 for 1 cycle, increment tap, clear slip_cnt, then go to SETTLE; otherwise the lane fails (o_lane_ok[lane]=0) and the FSM SHALL go to NEXT.
REQ-028 NEXT: if lane == NUM_LANES-1, SHALL go to DONE; otherwise SHALL increment lane and go to LOAD.
REQ-029 DONE: SHALL set o_done=1 and o_busy=0, then return to IDLE; o_done SHALL remain 1 in IDLE.
REQ-030 i_start while o_busy=1 SHALL be ignored.
REQ-031 At most one bit of o_bitslip | o_dly_ce | o_dly_ld SHALL be high in any cycle.
REQ-032 Counters SHALL saturate and never wrap: slip_cnt ≤ WORDWIDTH-1 and tap ≤ MAX_TAPS-1.
REQ-033 o_tap SHALL show the tap of the current lane and SHALL hold the last lane's value in IDLE.

Reset
REQ-034 When i_rst_n=0, regardless of state or pulses in flight, the FSM SHALL be in IDLE and every output SHALL be 0.
REQ-035 On deassertion of i_rst_n, the block SHALL wait in IDLE for i_start; it SHALL NOT auto-start.

Structure
REQ-036 Package lvds_rx_pkg SHALL hold the state encoding, default TRAIN_PATTERN, and WORDWIDTH/NUM_LANES defaults shared with the receiver.
REQ-037 Sub-module lvds_align_timer SHALL implement the loadable SETTLE down-counter with a done flag.

Verification
REQ-038 With all lanes equal to 111000 from the start, i_start -> no slips, no taps; o_done after 4×(1+1+4+8+1)+1 cycles; o_lane_ok=4'b1111.
REQ-039 With lane 2 rotated by 2 bits (100011), 2 bitslip pulses on o_bitslip[2] followed by a pattern match -> lane locks, tap=0.
REQ-040 With lane 1 never matching -> 5 slips per tap, 31 CE pulses, o_lane_ok[1]=0, other lanes =1, o_tap=31 when lane 1 ends.
REQ-041 With a single mismatch injected at match 7 of lane 0 -> SLIP issued, match_cnt restarts, lane locks after 8 new matches.
REQ-042 With i_rst_n pulsed low during TAP of lane 3 -> all outputs 0 at once; IDLE held until a new i_start; a second i_start while busy is ignored.

Source files
------------

// File: rtl/lvds_rx_pkg.sv
// Shared LVDS receiver definitions: lane geometry, training word and the
// state encoding of the word-alignment controller.
package lvds_rx_pkg;

  localparam int unsigned LVDS_NUM_LANES = 4;
  localparam int unsigned LVDS_WORDWIDTH = 6;
  localparam logic [LVDS_WORDWIDTH-1:0] LVDS_TRAIN_PATTERN = 6'b111000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_TAP,
    ST_NEXT,
    ST_DONE
  } align_state_e;

endpackage

// File: rtl/lvds_align_timer.sv
// Loadable down-counter that times the settle window after every delay or
// bitslip action; done_o is high once the count has drained to zero.
module lvds_align_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = count_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lvds_align_ctrl.sv
// Per-lane LVDS word alignment: bitslips through every phase of a word, then
// steps the input delay one tap, until the training pattern is seen MATCH_CNT times.
module lvds_align_ctrl
  import lvds_rx_pkg::*;
#(
  parameter int                   NUM_LANES     = LVDS_NUM_LANES,
  parameter int                   WORDWIDTH     = LVDS_WORDWIDTH,
  parameter logic [WORDWIDTH-1:0] TRAIN_PATTERN = LVDS_TRAIN_PATTERN,
  parameter int                   SETTLE_CYC    = 4,
  parameter int                   MATCH_CNT     = 8,
  parameter int                   MAX_TAPS      = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic [NUM_LANES*WORDWIDTH-1:0] i_lane_words,
  output logic [NUM_LANES-1:0]           o_bitslip,
  output logic [NUM_LANES-1:0]           o_dly_ce,
  output logic                           o_dly_inc,
  output logic [NUM_LANES-1:0]           o_dly_ld,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [NUM_LANES-1:0]           o_lane_ok,
  output logic [4:0]                     o_tap
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int SLIP_W = $clog2(WORDWIDTH);
  localparam int MC_W   = $clog2(MATCH_CNT + 1);
  localparam int TMR_W  = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

  align_state_e          state_q, state_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [4:0]            tap_q, tap_d;
  logic [SLIP_W-1:0]     slip_q, slip_d;
  logic [MC_W-1:0]       match_q, match_d;
  logic [NUM_LANES-1:0]  lane_ok_q, lane_ok_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [NUM_LANES-1:0]  lane_sel;
  logic [WORDWIDTH-1:0]  cur_word;
  logic                  settle_load;
  logic                  settle_done;

  assign lane_sel = NUM_LANES'(1) << lane_q;
  assign cur_word = i_lane_words[lane_q*WORDWIDTH +: WORDWIDTH];

  // The settle window restarts whenever the FSM enters SETTLE from an action state.
  assign settle_load = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);

  lvds_align_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .load_i  (settle_load),
    .count_i (TMR_W'(SETTLE_CYC)),
    .done_o  (settle_done)
  );

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    tap_d     = tap_q;
    slip_d    = slip_q;
    match_d   = match_q;
    lane_ok_d = lane_ok_q;
    busy_d    = busy_q;
    done_d    = done_q;
    o_bitslip = '0;
    o_dly_ce  = '0;
    o_dly_ld  = '0;
    o_dly_inc = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d   = ST_LOAD;
          lane_d    = '0;
          lane_ok_d = '0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
        end
      end
      ST_LOAD: begin
        o_dly_ld = lane_sel;
        tap_d    = '0;
        slip_d   = '0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_done) begin
          match_d = '0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (cur_word == TRAIN_PATTERN) begin
          match_d = match_q + 1'b1;
          if (match_d == MC_W'(MATCH_CNT)) begin
            lane_ok_d[lane_q] = 1'b1;
            state_d           = ST_NEXT;
          end
        end else if (slip_q < SLIP_W'(WORDWIDTH - 1)) begin
          state_d = ST_SLIP;
        end else begin
          state_d = ST_TAP;
        end
      end
      ST_SLIP: begin
        o_bitslip = lane_sel;
        if (slip_q < SLIP_W'(WORDWIDTH - 1)) begin
          slip_d = slip_q + 1'b1;
        end
        state_d = ST_SETTLE;
      end
      ST_TAP: begin
        // Out of taps means every phase at every delay failed: give up on the lane.
        if (tap_q < 5'(MAX_TAPS - 1)) begin
          o_dly_ce  = lane_sel;
          o_dly_inc = 1'b1;
          tap_d     = tap_q + 1'b1;
          slip_d    = '0;
          state_d   = ST_SETTLE;
        end else begin
          lane_ok_d[lane_q] = 1'b0;
          state_d           = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (lane_q == LANE_W'(NUM_LANES - 1)) begin
          state_d = ST_DONE;
        end else begin
          lane_d  = lane_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      lane_q    <= '0;
      tap_q     <= '0;
      slip_q    <= '0;
      match_q   <= '0;
      lane_ok_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      tap_q     <= tap_d;
      slip_q    <= slip_d;
      match_q   <= match_d;
      lane_ok_q <= lane_ok_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_lane_ok = lane_ok_q;
  assign o_tap     = tap_q;

endmodule

// File: tb/tb_lvds_align_ctrl.sv
// Drives lvds_align_ctrl with an emulated deserializer per lane and compares
// pulse counts, lock results and training time against an arithmetic model.
module tb_lvds_align_ctrl;

  localparam int NL = 4;
  localparam int WW = 6;
  localparam logic [WW-1:0] TP = 6'b111000;

  logic             clk = 1'b0;
  logic             rstN;
  logic             startReq;
  logic [NL*WW-1:0] laneWords;
  logic [NL-1:0]    o_bitslip, o_dly_ce, o_dly_ld, o_lane_ok;
  logic             o_dly_inc, o_busy, o_done;
  logic [4:0]       o_tap;
  logic [23:0]      allOuts;

  assign allOuts = {o_bitslip, o_dly_ce, o_dly_inc, o_dly_ld, o_busy, o_done, o_lane_ok, o_tap};

  lvds_align_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_start      (startReq),
    .i_lane_words (laneWords),
    .o_bitslip    (o_bitslip),
    .o_dly_ce     (o_dly_ce),
    .o_dly_inc    (o_dly_inc),
    .o_dly_ld     (o_dly_ld),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_lane_ok    (o_lane_ok),
    .o_tap        (o_tap)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Deserializer emulation: 'needed' bitslips remain until the word lines up,
  // and data is only valid once the delay reaches 'goodTap'.
  int needed [NL];
  int goodTap [NL];
  int emTap [NL];
  int glitchCd [NL];
  bit stuck [NL];
  bit glitchEn [NL];
  bit prevSlip [NL];
  int slipCnt [NL];
  int ceCnt [NL];
  int ldCnt [NL];
  int tapEnd [NL];
  int violations;

  function automatic logic [WW-1:0] rotl(input logic [WW-1:0] w, input int n);
    logic [2*WW-1:0] d;
    d = {w, w} << n;
    return d[2*WW-1:WW];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [WW-1:0] lw;
    bit glitchNow;
    forever begin
      @(negedge clk);
      if ($countones(o_bitslip | o_dly_ce | o_dly_ld) > 1) violations++;
      for (int k = 0; k < NL; k++) begin
        glitchNow = 1'b0;
        if (glitchCd[k] > 0) begin
          glitchCd[k]--;
          glitchNow = (glitchCd[k] == 0);
        end
        if (o_dly_ld[k]) begin
          ldCnt[k]++;
          emTap[k] = 0;
          if (k > 0) tapEnd[k-1] = int'(o_tap);
          if (glitchEn[k]) glitchCd[k] = 12;
        end
        if (o_bitslip[k]) begin
          slipCnt[k]++;
          if (prevSlip[k]) violations++;
          if (!stuck[k]) needed[k] = (needed[k] + WW - 1) % WW;
        end
        prevSlip[k] = o_bitslip[k];
        if (o_dly_ce[k]) begin
          ceCnt[k]++;
          emTap[k]++;
          if (!o_dly_inc) violations++;
        end
        if (emTap[k] >= goodTap[k] && !glitchNow) begin
          lw = rotl(TP, needed[k]);
        end else begin
          lw = WW'($urandom);
          if (lw == TP) lw = ~lw;
        end
        laneWords[k*WW +: WW] = lw;
      end
    end
  end

  task automatic setLane(input int k, input int n0, input int g, input bit stk, input bit gl);
    needed[k]   = n0;
    goodTap[k]  = g;
    stuck[k]    = stk;
    glitchEn[k] = gl;
    glitchCd[k] = 0;
  endtask

  task automatic setAligned();
    for (int k = 0; k < NL; k++) setLane(k, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic clearCounters();
    violations = 0;
    for (int k = 0; k < NL; k++) begin
      slipCnt[k] = 0; ceCnt[k] = 0; ldCnt[k] = 0; tapEnd[k] = -1; prevSlip[k] = 1'b0;
    end
  endtask

  // Outcome of one lane: k slips at tap g align the word; every failed attempt
  // costs settle(5)+check(1)+action(1) cycles.
  task automatic modelLane(input int n0, input int g, input bit gl,
                           output int s, output int c, output int tap, output bit ok, output int cyc);
    if (g <= 31) begin
      c   = g;
      s   = 5 * g + ((((n0 - 5 * g) % 6) + 6) % 6);
      tap = g;
      ok  = 1'b1;
      cyc = 15 + 7 * (s + c);
      if (gl) begin
        s   += 1;
        cyc += 13;
      end
    end else begin
      s   = 5 * 32;
      c   = 31;
      tap = 31;
      ok  = 1'b0;
      cyc = 2 + 7 * (s + c + 1);
    end
  endtask

  task automatic applyStimulus(input string name, input int midStartAt);
    int expS [NL];
    int expC [NL];
    int expT [NL];
    int laneCyc;
    int expCyc;
    int cyc;
    bit okb;
    logic [NL-1:0] expOk;
    expCyc = 1;
    for (int k = 0; k < NL; k++) begin
      modelLane(needed[k], goodTap[k], glitchEn[k], expS[k], expC[k], expT[k], okb, laneCyc);
      expOk[k] = okb;
      expCyc  += laneCyc;
    end
    clearCounters();
    @(posedge clk); #1 startReq = 1'b1;
    @(posedge clk); #1 startReq = 1'b0;
    checkOutput({name, " busy_after_start"}, 32'(o_busy), 1);
    checkOutput({name, " done_cleared"}, 32'({o_done, o_lane_ok}), 0);
    cyc = 0;
    while (!o_done && cyc < expCyc + 50) begin
      @(posedge clk); #1;
      cyc++;
      startReq = (cyc == midStartAt);
    end
    startReq = 1'b0;
    checkOutput({name, " done_cycles"}, 32'(cyc), 32'(expCyc));
    checkOutput({name, " busy_end"}, 32'(o_busy), 0);
    checkOutput({name, " lane_ok"}, 32'(o_lane_ok), 32'(expOk));
    checkOutput({name, " last_tap"}, 32'(o_tap), 32'(expT[NL-1]));
    checkOutput({name, " violations"}, 32'(violations), 0);
    for (int k = 0; k < NL; k++) begin
      checkOutput($sformatf("%s slips[%0d]", name, k), 32'(slipCnt[k]), 32'(expS[k]));
      checkOutput($sformatf("%s ce[%0d]", name, k), 32'(ceCnt[k]), 32'(expC[k]));
      checkOutput($sformatf("%s ld[%0d]", name, k), 32'(ldCnt[k]), 1);
      if (k < NL - 1) checkOutput($sformatf("%s tap_end[%0d]", name, k), 32'(tapEnd[k]), 32'(expT[k]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    rstN      = 1'b0;
    startReq  = 1'b0;
    laneWords = '0;
    setAligned();
    clearCounters();
    repeat (3) @(posedge clk);
    #1 checkOutput("reset_outputs", 32'(allOuts), 0);
    rstN = 1'b1;
    repeat (10) @(posedge clk);
    #1 checkOutput("idle_no_autostart", 32'({o_busy, o_done, o_dly_ld}), 0);

    applyStimulus("aligned", -1);

    setAligned(); setLane(2, 2, 0, 1'b0, 1'b0);
    applyStimulus("lane2_rot2", -1);

    setAligned(); setLane(1, 0, 40, 1'b0, 1'b0);
    applyStimulus("lane1_dead", -1);

    setAligned(); setLane(0, 0, 0, 1'b1, 1'b1);
    applyStimulus("lane0_glitch", -1);

    // Reset in the middle of a delay step of the last lane.
    setAligned(); setLane(3, 0, 40, 1'b0, 1'b0);
    @(posedge clk); #1 startReq = 1'b1;
    @(posedge clk); #1 startReq = 1'b0;
    cyc = 0;
    while (!o_dly_ce[3] && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("rst reached_tap3", 32'(o_dly_ce[3]), 1);
    #1 rstN = 1'b0;
    #1 checkOutput("rst outputs_zero", 32'(allOuts), 0);
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    clearCounters();
    repeat (20) @(posedge clk);
    #1 checkOutput("rst held_idle", 32'({o_busy, o_done, o_lane_ok}), 0);
    checkOutput("rst no_loads", 32'(ldCnt[0] + ldCnt[1] + ldCnt[2] + ldCnt[3]), 0);
    setAligned();
    applyStimulus("after_rst_restart_ignored", 10);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NL; k++) begin
        setLane(k, int'($urandom_range(0, 5)),
                ($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(0, 2)), 1'b0, 1'b0);
      end
      applyStimulus($sformatf("rand%0d", r), ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 40)) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
